// File: rtl/opb_reg_pkg.sv
// Shared definitions for the PPC-to-fabric OPB register: word offsets, FSM
// states and the OPB (big-endian bit order) to register bit-order helpers.
package opb_reg_pkg;

   localparam logic OFS_DATA  = 1'b0;
   localparam logic OFS_WRCNT = 1'b1;

   typedef enum logic {IDLE, ACK} state_t;

   // OPB numbers bit 0 as the MSB, so DBus[i] lands in register bit [31-i].
   function automatic logic [31:0] opbToReg(input logic [0:31] opbWord);
      logic [31:0] regWord;
      for (int i = 0; i < 32; i++) begin
         regWord[31-i] = opbWord[i];
      end
      return regWord;
   endfunction

   function automatic logic [0:31] regToOpb(input logic [31:0] regWord);
      logic [0:31] opbWord;
      for (int i = 0; i < 32; i++) begin
         opbWord[i] = regWord[31-i];
      end
      return opbWord;
   endfunction

endpackage

// File: rtl/opb_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take the new data, the rest
// keep the old register value. Lane 3 covers bits [31:24].
module opb_byte_merge
   import opb_reg_pkg::*;
(
   input  logic [31:0] i_old,
   input  logic [31:0] i_new,
   input  logic [3:0]  i_laneEn,
   output logic [31:0] o_merged
);

   always_comb begin
      o_merged = i_old;
      for (int k = 0; k < 4; k++) begin
         if (i_laneEn[k]) begin
            o_merged[8*k +: 8] = i_new[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave with one PPC-written data register driven to user logic plus a
// read-only 16-bit write counter. Define OPB_REG_WR_STROBE_EN for user_data_valid.
module opb_register_ppc2simulink
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h00000000,
   parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex5",
   parameter logic [31:0] C_INIT_VALUE = 32'h00000000
)
(
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   output logic                    Sl_xferAck,
   output logic [31:0]             user_data_out
`ifdef OPB_REG_WR_STROBE_EN
   ,
   output logic                    user_data_valid
`endif
);

   state_t      r_state;
   logic [31:0] r_data;
   logic [31:0] r_rdData;
   logic [15:0] r_wrCount;
`ifdef OPB_REG_WR_STROBE_EN
   logic        r_dataValid;
`endif

   logic        w_hit;
   logic        w_offset;
   logic        w_anyBe;
   logic [3:0]  w_laneEn;
   logic [31:0] w_wrData;
   logic [31:0] w_merged;

   // Only address bit 29 is decoded, so both words alias across the window.
   assign w_hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign w_offset = OPB_ABus[29];
   assign w_anyBe  = |OPB_BE;
   assign w_laneEn = OPB_BE;
   assign w_wrData = opbToReg(OPB_DBus);

   opb_byte_merge u_merge (
      .i_old    (r_data),
      .i_new    (w_wrData),
      .i_laneEn (w_laneEn),
      .o_merged (w_merged)
   );

   // Capture and read-data load both happen on the IDLE->ACK edge, so the
   // read bus is non-zero only in the single ACK cycle (OR-bus friendly).
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_state   <= IDLE;
         r_data    <= C_INIT_VALUE;
         r_rdData  <= '0;
         r_wrCount <= '0;
`ifdef OPB_REG_WR_STROBE_EN
         r_dataValid <= 1'b0;
`endif
      end else begin
         r_rdData <= '0;
`ifdef OPB_REG_WR_STROBE_EN
         r_dataValid <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_state <= ACK;
                  if (OPB_RNW) begin
                     r_rdData <= (w_offset == OFS_WRCNT) ? {16'h0000, r_wrCount} : r_data;
                  end else if ((w_offset == OFS_DATA) && w_anyBe) begin
                     r_data    <= w_merged;
                     r_wrCount <= r_wrCount + 16'd1;
`ifdef OPB_REG_WR_STROBE_EN
                     r_dataValid <= 1'b1;
`endif
                  end
               end
            end
            ACK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign Sl_xferAck    = (r_state == ACK);
   assign Sl_DBus       = regToOpb(r_rdData);
   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign user_data_out = r_data;
`ifdef OPB_REG_WR_STROBE_EN
   assign user_data_valid = r_dataValid;
`endif

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Self-checking bench for opb_register_ppc2simulink: directed and random OPB
// transfers against a behavioural register/counter model checked every cycle.
module tb_opb_register_ppc2simulink;

   localparam logic [31:0] BASE = 32'h00000100;
   localparam logic [31:0] HIGH = 32'h000001FF;
   localparam logic [31:0] INIT = 32'h0BADF00D;

   logic        OPB_Clk = 1'b0;
   logic        OPB_Rst_n = 1'b0;
   logic [0:31] OPB_ABus = '0;
   logic [0:3]  OPB_BE = '0;
   logic [0:31] OPB_DBus = '0;
   logic        OPB_RNW = 1'b1;
   logic        OPB_select = 1'b0;
   logic        OPB_seqAddr = 1'b0;
   logic [0:31] Sl_DBus;
   logic        Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
   logic [31:0] user_data_out;
`ifdef OPB_REG_WR_STROBE_EN
   logic        user_data_valid;
`endif

   int testsRun = 0;
   int testsFailed = 0;
   int pulseCount = 0;

   // Behavioural model state
   logic [31:0] mData = INIT;
   logic [15:0] mCount = '0;
   logic        expAck = 1'b0;
   logic [31:0] expDbus = '0;
   logic        expValid = 1'b0;

   always #5 OPB_Clk = ~OPB_Clk;

   opb_register_ppc2simulink #(
      .C_BASEADDR   (BASE),
      .C_HIGHADDR   (HIGH),
      .C_OPB_AWIDTH (32),
      .C_OPB_DWIDTH (32),
      .C_FAMILY     ("virtex5"),
      .C_INIT_VALUE (INIT)
   ) dut (
      .OPB_Clk       (OPB_Clk),
      .OPB_Rst_n     (OPB_Rst_n),
      .OPB_ABus      (OPB_ABus),
      .OPB_BE        (OPB_BE),
      .OPB_DBus      (OPB_DBus),
      .OPB_RNW       (OPB_RNW),
      .OPB_select    (OPB_select),
      .OPB_seqAddr   (OPB_seqAddr),
      .Sl_DBus       (Sl_DBus),
      .Sl_errAck     (Sl_errAck),
      .Sl_retry      (Sl_retry),
      .Sl_toutSup    (Sl_toutSup),
      .Sl_xferAck    (Sl_xferAck),
      .user_data_out (user_data_out)
`ifdef OPB_REG_WR_STROBE_EN
      ,
      .user_data_valid (user_data_valid)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: one acknowledged transfer per hit, with a mandatory gap cycle.
   always @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      logic [31:0] mask;
      if (!OPB_Rst_n) begin
         mData = INIT;
         mCount = '0;
         expAck = 1'b0;
         expDbus = '0;
         expValid = 1'b0;
      end else if (expAck) begin
         expAck = 1'b0;
         expDbus = '0;
         expValid = 1'b0;
      end else if (OPB_select && (OPB_ABus >= BASE) && (OPB_ABus <= HIGH)) begin
         expAck = 1'b1;
         expDbus = '0;
         expValid = 1'b0;
         if (OPB_RNW) begin
            expDbus = ((OPB_ABus & 32'h4) != 0) ? {16'h0000, mCount} : mData;
         end else if (((OPB_ABus & 32'h4) == 0) && (OPB_BE != 4'b0000)) begin
            for (int k = 0; k < 4; k++) begin
               if (OPB_BE[k]) begin
                  mask = 32'hFF << (24 - 8*k);
                  mData = (mData & ~mask) | (OPB_DBus & mask);
               end
            end
            mCount = mCount + 16'd1;
            expValid = 1'b1;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge OPB_Clk) begin
      if (OPB_Rst_n) begin
         checkOutput("xferAck", {31'b0, Sl_xferAck}, {31'b0, expAck});
         checkOutput("Sl_DBus", Sl_DBus, expDbus);
         checkOutput("user_data_out", user_data_out, mData);
         checkOutput("tiedOffs", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
`ifdef OPB_REG_WR_STROBE_EN
         checkOutput("user_data_valid", {31'b0, user_data_valid}, {31'b0, expValid});
         if (user_data_valid) pulseCount++;
`endif
      end
   end

   // One OPB transfer; lat is the cycle count to ack, or -1 if none arrived.
   task automatic applyStimulus(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                                input logic [31:0] data, output logic [31:0] rdata, output int lat);
      @(negedge OPB_Clk);
      OPB_ABus = addr;
      OPB_RNW = rnw;
      OPB_BE = be;
      OPB_DBus = data;
      OPB_select = 1'b1;
      lat = -1;
      rdata = '0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge OPB_Clk);
         if (Sl_xferAck) begin
            lat = c;
            rdata = Sl_DBus;
            break;
         end
      end
      OPB_select = 1'b0;
      OPB_RNW = 1'b1;
      OPB_BE = '0;
      OPB_DBus = '0;
      @(negedge OPB_Clk);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] addr;
      int lat;
      int ackCount;
      logic inRange;

      repeat (3) @(negedge OPB_Clk);
      #2 OPB_Rst_n = 1'b1;
      checkOutput("reset_ack", {31'b0, Sl_xferAck}, 32'h0);
      checkOutput("reset_dbus", Sl_DBus, 32'h0);
      checkOutput("reset_user", user_data_out, INIT);

      applyStimulus(BASE, 1'b1, 4'b1111, 32'h0, rd, lat);
      checkOutput("read_init", rd, INIT);
      checkOutput("read_init_lat", lat, 1);
      applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0, rd, lat);
      checkOutput("read_cnt0", rd, 32'h0);
      checkOutput("read_cnt0_lat", lat, 1);

      applyStimulus(BASE, 1'b0, 4'b1111, 32'hDEADBEEF, rd, lat);
      checkOutput("wr_full", user_data_out, 32'hDEADBEEF);
      checkOutput("wr_full_lat", lat, 1);
      applyStimulus(BASE + 4, 1'b1, 4'b1111, 32'h0, rd, lat);
      checkOutput("cnt_after_1", rd, 32'h1);

      applyStimulus(BASE, 1'b0, 4'b0101, 32'h11223344, rd, lat);
      checkOutput("wr_be0101", user_data_out, 32'hDE22BE44);
      applyStimulus(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF, rd, lat);
      checkOutput("wr_be0000_lat", lat, 1);
      checkOutput("wr_be0000", user_data_out, 32'hDE22BE44);
      applyStimulus(BASE + 4, 1'b0, 4'b1111, 32'h55555555, rd, lat);
      checkOutput("wr_ofs1_ignored", user_data_out, 32'hDE22BE44);
      applyStimulus(BASE + 32'h84, 1'b1, 4'b0000, 32'h0, rd, lat);
      checkOutput("cnt_after_2_alias", rd, 32'h2);
      applyStimulus(BASE + 32'h40, 1'b1, 4'b0000, 32'h0, rd, lat);
      checkOutput("data_alias", rd, 32'hDE22BE44);

      // Select held through the ACK cycle must give exactly one acknowledge.
      @(negedge OPB_Clk);
      OPB_ABus = BASE;
      OPB_RNW = 1'b1;
      OPB_select = 1'b1;
      ackCount = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge OPB_Clk);
         if (c == 1) OPB_select = 1'b0;
         if (Sl_xferAck) ackCount++;
      end
      checkOutput("held_select_acks", ackCount, 1);

      applyStimulus(HIGH + 4, 1'b0, 4'b1111, 32'h01020304, rd, lat);
      checkOutput("oor_high_noack", lat, -1);
      applyStimulus(BASE - 4, 1'b0, 4'b1111, 32'h01020304, rd, lat);
      checkOutput("oor_low_noack", lat, -1);
      checkOutput("oor_unchanged", user_data_out, 32'hDE22BE44);

      for (int n = 0; n < 300; n++) begin
         addr = 32'hF0 + $urandom_range(0, 32'h120);
         inRange = (addr >= BASE) && (addr <= HIGH);
         applyStimulus(addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, rd, lat);
         checkOutput("rand_lat", lat, inRange ? 1 : -1);
      end

      // Jump the counter close to wrap instead of issuing 65k writes.
      @(negedge OPB_Clk);
      dut.r_wrCount = 16'hFFFD;
      mCount = 16'hFFFD;
      for (int n = 0; n < 3; n++) begin
         applyStimulus(BASE, 1'b0, 4'b1111, 32'hA0B0C0D0 + n, rd, lat);
      end
      applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0, rd, lat);
      checkOutput("cnt_wrap", rd, 32'h0);

      // Reset asserted in the middle of an ACK cycle.
      @(negedge OPB_Clk);
      OPB_ABus = BASE;
      OPB_RNW = 1'b0;
      OPB_BE = 4'b1111;
      OPB_DBus = 32'h12345678;
      OPB_select = 1'b1;
      @(posedge OPB_Clk);
      #2;
      checkOutput("ack_before_reset", {31'b0, Sl_xferAck}, 32'h1);
      OPB_Rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_ack", {31'b0, Sl_xferAck}, 32'h0);
      checkOutput("reset_mid_dbus", Sl_DBus, 32'h0);
      checkOutput("reset_mid_user", user_data_out, INIT);
      OPB_select = 1'b0;
      OPB_RNW = 1'b1;
      OPB_BE = '0;
      repeat (2) @(negedge OPB_Clk);
      #2 OPB_Rst_n = 1'b1;
      applyStimulus(BASE + 4, 1'b1, 4'b0000, 32'h0, rd, lat);
      checkOutput("cnt_after_reset", rd, 32'h0);
      applyStimulus(BASE, 1'b1, 4'b0000, 32'h0, rd, lat);
      checkOutput("data_after_reset", rd, INIT);

`ifdef OPB_REG_WR_STROBE_EN
      pulseCount = 0;
      applyStimulus(BASE, 1'b0, 4'b1000, 32'h11000000, rd, lat);
      applyStimulus(BASE, 1'b0, 4'b1111, user_data_out, rd, lat);
      applyStimulus(BASE, 1'b0, 4'b0011, 32'h00003344, rd, lat);
      applyStimulus(BASE, 1'b1, 4'b1111, 32'h0, rd, lat);
      applyStimulus(BASE + 4, 1'b0, 4'b1111, 32'h0, rd, lat);
      checkOutput("strobe_pulses", pulseCount, 3);
`endif

      repeat (2) @(negedge OPB_Clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/opb_register_ppc2simulink.md
Name: opb_register_ppc2simulink

Overview:
OPB slave holding one 32-bit register that the PPC writes and fabric (Simulink user logic) reads. It is the write-direction counterpart of the simulink2ppc status registers: software drives `user_data_out` into user logic.
- Byte-enabled writes supported.
- Data register readback supported.
- A read-only write counter lets software confirm that updates landed.
- Single clock domain; user logic runs on `OPB_Clk`.

Parameters:
- C_BASEADDR, 32'h00000000, first byte address of the slave window.
- C_HIGHADDR, 32'h000000FF, last byte address of the window; any address in [BASE, HIGH] hits.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
- C_FAMILY, "virtex5", target family string; no functional effect.
- C_INIT_VALUE, 32'h00000000, reset value of the data register.

Ports:
- OPB_Clk  in  1  sole clock; OPB and user side.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  OPB address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer in progress.
- OPB_seqAddr  in  1  sequential hint; ignored.
- Sl_DBus  out  [0:31]  read data; zero when not acking.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- user_data_out  out  [31:0]  register value to user logic.

Behaviour:
- Bit mapping: OPB DBus[i] maps to register bit [31-i]. BE[0] maps to bits [31:24]; BE[3] maps to bits [7:0].
- Address decode:
  - hit = OPB_select & (ABus >= C_BASEADDR) & (ABus <= C_HIGHADDR).
  - offset = ABus[29] selects the word: 0 = data register (RW), 1 = write counter (RO).
  - Both words alias across the window (only bit 29 is decoded).
- FSM: IDLE and ACK states.
  - IDLE -> ACK when hit. The register capture happens on this edge.
  - ACK -> IDLE unconditionally.
  - Sl_xferAck = (state == ACK), so acknowledge latency is one cycle after select.
  - A transfer held in select while in ACK is not re-acknowledged. Maximum throughput is one transfer per 2 cycles.
- Write (RNW = 0, offset 0), registered on the IDLE -> ACK edge:
  - Each byte lane with BE set takes the OPB_DBus lane; other lanes hold their value.
  - BE = 0000 still acknowledges but changes nothing.
  - The counter increments if any BE bit is set.
- Write to offset 1: acknowledged and ignored; no counter change.
- Read:
  - Sl_DBus is registered on the same edge, so it is valid exactly while Sl_xferAck = 1.
  - Offset 0 returns the data register.
  - Offset 1 returns {16'h0, wr_count[15:0]}.
  - BE is ignored on reads.
- Sl_DBus is 0 in every cycle that Sl_xferAck = 0 (OR-bus requirement).
- wr_count: 16-bit, wraps FFFF -> 0000.
- user_data_out updates on the cycle Sl_xferAck rises (registered output, one cycle after select).
- Reset (asynchronous, any time, including mid-transfer):
  - state = IDLE, Sl_xferAck = 0, Sl_DBus = 0.
  - data register = C_INIT_VALUE, wr_count = 0.
  - An interrupted transfer is never acknowledged.
- Select dropped by the master while in ACK: ignored. The capture has already occurred.

Optional Feature:
- Macro: OPB_REG_WR_STROBE_EN.
- Defined:
  - Adds output port user_data_valid (1 bit, reset 0).
  - It pulses high for exactly one cycle, coincident with Sl_xferAck, on every counted data write, including writes whose bytes equal the old value.
- Undefined: the port is absent; all other behaviour is identical.

Decomposition:
- Package opb_reg_pkg holds:
  - localparams for word offsets (OFS_DATA = 0, OFS_WRCNT = 1);
  - FSM state typedef {IDLE, ACK};
  - the byte-lane bit-reverse helper function.
- One sub-module: opb_byte_merge. Combinational; it takes old value, OPB data and BE and returns the merged 32-bit word. The top module holds the FSM, counter and decode.

Test Plan:
- Reset then read offset 0 and offset 4 -> Sl_DBus = C_INIT_VALUE, then 0x00000000. Each Sl_xferAck arrives exactly 1 cycle after select; Sl_DBus = 0 outside ack.
- Write 0xDEADBEEF with BE = 1111 -> user_data_out = 32'hDEADBEEF the cycle ack rises; readback of wr_count = 1.
- Then write 0x11223344 with BE = 0101 -> user_data_out = 32'hDE22BE44; counter = 2. Then write with BE = 0000 -> value unchanged, counter still 2.
- Hold select high 5 cycles on one read -> exactly one Sl_xferAck. Out-of-range address (C_HIGHADDR+4) with select -> no ack, no state change.
- Preload the counter via 65535 writes, then 1 more -> wr_count reads 0x0000. Assert OPB_Rst_n low during the ACK cycle -> ack and Sl_DBus drop immediately; register = C_INIT_VALUE.
- With OPB_REG_WR_STROBE_EN defined: 3 data writes plus 1 read plus 1 offset-1 write -> exactly 3 single-cycle user_data_valid pulses, each aligned with its ack.
